// File: rtl/dds_pkg.sv
// Shared widths, shape encodings, config payload and sine table helpers for the DDS generator.
// Build option: DDS_SIN_QUARTER_EN selects the quarter-wave sine ROM in dds_sine_lut.
package dds_pkg;

  localparam int unsigned ACC_W     = 16;
  localparam int unsigned PH_W      = 10;
  localparam int unsigned OUT_W     = 12;
  localparam int unsigned AMP_W     = 11;
  localparam int unsigned PM_W      = 13;
  localparam int unsigned AMP_SHIFT = 11;

  localparam logic [1:0] SHAPE_SIN = 2'd0;
  localparam logic [1:0] SHAPE_TRI = 2'd1;
  localparam logic [1:0] SHAPE_SQR = 2'd2;

  localparam logic signed [OUT_W-1:0] WAVE_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] WAVE_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  // pi in Q30 and 0.5 in Q30, used only while building the sine tables
  localparam longint PI_Q30   = 64'sd3373259426;
  localparam longint HALF_Q30 = 64'sd536870912;

  // Amplitude and shape travel as one word so a sample never mixes old and new settings
  typedef struct packed {
    logic [AMP_W-1:0] amp;
    logic [1:0]       shape;
  } dds_cfg_t;

  // round(2047 * sin(2*pi*q/1024)) for q in 0..256, evaluated at elaboration (Taylor series, Q30)
  function automatic logic signed [OUT_W-1:0] sin_quarter(input int q);
    longint x;
    longint term;
    longint sum;
    x    = (longint'(q) * PI_Q30) / 64'sd512;
    term = x;
    sum  = x;
    for (int k = 1; k <= 9; k++) begin
      term = (term * x) >>> 30;
      term = (term * x) >>> 30;
      term = -(term / longint'(4 * k * k + 2 * k));
      sum  = sum + term;
    end
    return OUT_W'((sum * 64'sd2047 + HALF_Q30) >>> 30);
  endfunction

  // Full-period value built from the quarter wave by mirroring and sign inversion
  function automatic logic signed [OUT_W-1:0] sin_full(input int p);
    int u;
    int q;
    logic signed [OUT_W-1:0] v;
    u = p % 512;
    q = (u <= 256) ? u : 512 - u;
    v = sin_quarter(q);
    return (p >= 512) ? -v : v;
  endfunction

endpackage

// File: rtl/dds_sine_lut.sv
// Registered sine ROM: phase index in, signed sample out one clock later.
// Build option: DDS_SIN_QUARTER_EN uses a 256-entry quarter-wave table with mirroring;
// otherwise a full 1024-entry table. Both produce identical samples and latency.
module dds_sine_lut
  import dds_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PH_W-1:0]         phase_i,
  output logic signed [OUT_W-1:0] sample_o
);

  logic signed [OUT_W-1:0] sample_d;
  logic signed [OUT_W-1:0] sample_q;

`ifdef DDS_SIN_QUARTER_EN
  localparam int unsigned QA_W  = PH_W - 2;
  localparam int          QDEPTH = 1 << QA_W;

  logic signed [OUT_W-1:0] rom [QDEPTH];
  logic [QA_W-1:0]         addr_c;
  logic                    peak_c;
  logic signed [OUT_W-1:0] mag_c;

  for (genvar i = 0; i < QDEPTH; i++) begin : g_rom
    localparam logic signed [OUT_W-1:0] ENTRY = sin_quarter(i);
    assign rom[i] = ENTRY;
  end

  // Mirror the address in the second quarter, invert sign in the second half
  always_comb begin
    addr_c   = phase_i[QA_W-1:0];
    peak_c   = 1'b0;
    if (phase_i[PH_W-2]) begin
      addr_c = QA_W'({QA_W{1'b0}} - phase_i[QA_W-1:0]);
      peak_c = (phase_i[QA_W-1:0] == {QA_W{1'b0}});
    end
    mag_c    = peak_c ? WAVE_MAX : rom[addr_c];
    sample_d = phase_i[PH_W-1] ? -mag_c : mag_c;
  end
`else
  localparam int FDEPTH = 1 << PH_W;

  logic signed [OUT_W-1:0] rom [FDEPTH];

  for (genvar i = 0; i < FDEPTH; i++) begin : g_rom
    localparam logic signed [OUT_W-1:0] ENTRY = sin_full(i);
    assign rom[i] = ENTRY;
  end

  // Direct lookup over the whole period
  always_comb begin
    sample_d = rom[phase_i];
  end
`endif

  // Output register forms the wave stage
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_q <= '0;
    end else begin
      sample_q <= sample_d;
    end
  end

  assign sample_o = sample_q;

endmodule

// File: rtl/dds_generator.sv
// DDS generator: phase accumulator -> shape generator -> amplitude scaler, one sample per clock.
// Build option: DDS_SIN_QUARTER_EN (selects the sine ROM implementation inside dds_sine_lut).
module dds_generator
  import dds_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PM_W-1:0]         phase_M,
  input  logic [AMP_W-1:0]        signal_A,
  input  logic [1:0]              signal_shape,
  output logic signed [OUT_W-1:0] dds_out,
  output logic                    cycle_start
);

  localparam int unsigned SUM_W  = ACC_W + 1;
  localparam int unsigned RW     = OUT_W + 1;
  localparam int unsigned PROD_W = OUT_W + AMP_W;

  // S1: accumulator and active configuration
  logic [ACC_W-1:0] acc_d, acc_q;
  logic             primed_d, primed_q;
  dds_cfg_t         cfg_s1_d, cfg_s1_q;
  logic             start_s1_d, start_s1_q;
  logic [SUM_W-1:0] sum_c;
  logic             load_c;

  // S2: wave generation
  dds_cfg_t                cfg_s2_d, cfg_s2_q;
  logic                    start_s2_d, start_s2_q;
  logic signed [OUT_W-1:0] tw_d, tw_q;
  logic [PH_W-1:0]         ph_c;
  logic [PH_W-2:0]         u_c;
  logic signed [RW-1:0]    ramp_c;
  logic signed [OUT_W-1:0] lut_sample;
  logic signed [OUT_W-1:0] wave_c;

  // S3: amplitude scaling
  logic signed [PROD_W-1:0] prod_c;
  logic signed [OUT_W-1:0]  dds_d, dds_q;
  logic                     cs_d, cs_q;

  // Accumulate; reload configuration on the priming edge and on every carry
  always_comb begin
    sum_c      = {1'b0, acc_q} + SUM_W'(phase_M);
    load_c     = !primed_q || sum_c[ACC_W];
    acc_d      = sum_c[ACC_W-1:0];
    primed_d   = 1'b1;
    cfg_s1_d   = cfg_s1_q;
    start_s1_d = load_c;
    if (load_c) begin
      cfg_s1_d = '{amp: signal_A, shape: signal_shape};
    end
  end

  // Triangle and square wave from the phase index; sine comes from the ROM
  always_comb begin
    ph_c       = acc_q[ACC_W-1 -: PH_W];
    u_c        = ph_c[PH_W-2:0];
    ramp_c     = $signed({1'b0, u_c, 3'b000});
    cfg_s2_d   = cfg_s1_q;
    start_s2_d = start_s1_q;
    tw_d       = '0;
    case (cfg_s1_q.shape)
      SHAPE_TRI: begin
        if (ph_c[PH_W-1]) tw_d = OUT_W'(RW'(WAVE_MAX) - ramp_c);
        else              tw_d = OUT_W'(ramp_c + RW'(WAVE_MIN));
      end
      SHAPE_SQR: tw_d = ph_c[PH_W-1] ? WAVE_MIN : WAVE_MAX;
      default:   tw_d = '0;
    endcase
  end

  dds_sine_lut u_sine_lut (
    .clk      (clk),
    .rst      (rst),
    .phase_i  (ph_c),
    .sample_o (lut_sample)
  );

  // Scale the selected wave by the amplitude that travelled with it
  always_comb begin
    wave_c = (cfg_s2_q.shape == SHAPE_SIN) ? lut_sample : tw_q;
    prod_c = PROD_W'(wave_c) * PROD_W'($signed({1'b0, cfg_s2_q.amp}));
    dds_d  = OUT_W'(prod_c >>> AMP_SHIFT);
    cs_d   = start_s2_q;
  end

  // Pipeline registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      primed_q   <= 1'b0;
      cfg_s1_q   <= '0;
      start_s1_q <= 1'b0;
      cfg_s2_q   <= '0;
      start_s2_q <= 1'b0;
      tw_q       <= '0;
      dds_q      <= '0;
      cs_q       <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      primed_q   <= primed_d;
      cfg_s1_q   <= cfg_s1_d;
      start_s1_q <= start_s1_d;
      cfg_s2_q   <= cfg_s2_d;
      start_s2_q <= start_s2_d;
      tw_q       <= tw_d;
      dds_q      <= dds_d;
      cs_q       <= cs_d;
    end
  end

  assign dds_out     = dds_q;
  assign cycle_start = cs_q;

endmodule
